// File: rtl/shr_seq_ctrl_if.sv
// Command push bus between the host/vJTAG register file and shr_seq_ctrl.
interface shr_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_bank;
  logic [9:0] cmd_len;
  logic [7:0] cmd_rep;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_bank,
    output cmd_len,
    output cmd_rep,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_bank,
    input  cmd_len,
    input  cmd_rep,
    output cmd_ready
  );
endinterface

// File: rtl/shr_seq_ctrl.sv
// Command FIFO + sequencer driving trig/seq_length/bank_sel/clear controls of the shift-register
// pattern driver. Define SHR_SEQ_CTRL_LOOP_EN to add loop_en (re-push completed entries).
module shr_seq_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TRIG_W     = 2,
  parameter int GAP        = 8,
  parameter int CLR_CYCLES = 16,
  parameter int TO_MARGIN  = 64
) (
  input  logic          clk_in,
  input  logic          rst,
  shr_seq_ctrl_if.slave cmd,
  input  logic          abort,
  input  logic          syn,
`ifdef SHR_SEQ_CTRL_LOOP_EN
  input  logic          loop_en,
`endif
  output logic          trig,
  output logic [9:0]    seq_length,
  output logic [1:0]    bank_sel,
  output logic          clr_mode,
  output logic          clr_2_one,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 22;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TRIG  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_CLEAR = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  localparam logic [1:0] OP_PAT  = 2'b00;
  localparam logic [1:0] OP_ONE  = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [AW:0] CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  TRIG_LAST = 8'(TRIG_W - 1);
  localparam logic [7:0]  GAP_LAST  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
  localparam logic [7:0]  CLR_LAST  = 8'(CLR_CYCLES - 1);
  localparam logic [11:0] MARGIN_12 = 12'(TO_MARGIN);

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      cnt;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_host;
  logic             push_any;
  logic             loop_push;
  logic [ENT_W-1:0] host_ent;
  logic [ENT_W-1:0] push_data;
  logic [ENT_W-1:0] cur_ent;

  logic [1:0]  cur_op;
  logic [1:0]  cur_bank;
  logic [9:0]  cur_len;
  logic [7:0]  cur_rep;
  logic        bad_cmd;

  logic [2:0]  state;
  logic [7:0]  rep_cnt;
  logic [7:0]  ph_cnt;
  logic [11:0] to_cnt;
  logic [11:0] to_nxt;
  logic [11:0] to_limit;
  logic        to_hit;
  logic        timed_out;
  logic        syn_p0;
  logic        syn_rise;
  logic        gap_end;
  logic        more_reps;
  logic        cmd_done;

  assign cnt        = wr_ptr - rd_ptr;
  assign full       = (cnt == CNT_FULL);
  assign empty      = (cnt == '0);
  assign fifo_level = 3'(cnt);

  assign host_ent = {cmd.cmd_op, cmd.cmd_bank, cmd.cmd_len, cmd.cmd_rep};
  assign {cur_op, cur_bank, cur_len, cur_rep} = cur_ent;
  assign bad_cmd  = (cur_op == OP_RSVD) || ((cur_op == OP_PAT) && (cur_len == 10'd0));

  assign syn_rise  = syn && !syn_p0;
  assign to_limit  = {2'b00, cur_len} + MARGIN_12;
  assign to_nxt    = to_cnt + 12'd1;
  assign to_hit    = (to_nxt == to_limit);
  assign gap_end   = (state == S_GAP) && (ph_cnt == GAP_LAST);
  assign more_reps = (rep_cnt != 8'd0) && !timed_out;
  assign cmd_done  = gap_end && !abort && !more_reps && !timed_out;

`ifdef SHR_SEQ_CTRL_LOOP_EN
  // A completed entry goes back to the tail ahead of any host push this cycle.
  assign loop_push = cmd_done && loop_en && !full;
`else
  assign loop_push = 1'b0;
`endif

  assign cmd.cmd_ready = !full && !loop_push;
  assign push_host     = cmd.cmd_valid && cmd.cmd_ready && !abort;
  assign push_any      = push_host || loop_push;
  assign push_data     = loop_push ? cur_ent : host_ent;
  assign pop           = (state == S_IDLE) && !empty && !abort;
  assign busy          = (state != S_IDLE);

  // FIFO control: abort flushes and overrides any same-cycle push
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_any) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_any) mem[wr_ptr[AW-1:0]] <= push_data;
    if (pop)      cur_ent <= mem[rd_ptr[AW-1:0]];
  end

  // Sequencer: LOAD validates/latches, TRIG/WAIT track syn with timeout, GAP spaces repeats
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      trig       <= 1'b0;
      seq_length <= '0;
      bank_sel   <= '0;
      clr_mode   <= 1'b0;
      clr_2_one  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rep_cnt    <= '0;
      ph_cnt     <= '0;
      to_cnt     <= '0;
      timed_out  <= 1'b0;
      syn_p0     <= 1'b0;
    end else begin
      syn_p0 <= syn;
      done   <= cmd_done;
      case (state)
        S_IDLE: begin
          if (pop) state <= S_LOAD;
        end
        S_LOAD: begin
          timed_out <= 1'b0;
          ph_cnt    <= '0;
          if (abort) begin
            clr_mode  <= 1'b0;
            clr_2_one <= 1'b0;
            state     <= S_IDLE;
          end else if (bad_cmd) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (cur_op == OP_PAT) begin
            seq_length <= cur_len;
            bank_sel   <= cur_bank;
            clr_mode   <= 1'b0;
            clr_2_one  <= 1'b0;
            rep_cnt    <= (cur_rep == 8'd0) ? 8'd1 : cur_rep;
            trig       <= 1'b1;
            to_cnt     <= '0;
            state      <= S_TRIG;
          end else begin
            clr_mode  <= 1'b1;
            clr_2_one <= (cur_op == OP_ONE);
            rep_cnt   <= '0;
            state     <= S_CLEAR;
          end
        end
        S_TRIG, S_WAIT: begin
          to_cnt <= to_nxt;
          ph_cnt <= ph_cnt + 8'd1;
          if (abort) begin
            trig <= 1'b0;
            if (syn_rise) begin
              state <= S_IDLE;
            end else if (to_hit) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_DRAIN;
            end
          end else if (syn_rise) begin
            trig    <= 1'b0;
            rep_cnt <= rep_cnt - 8'd1;
            ph_cnt  <= '0;
            state   <= S_GAP;
          end else if (to_hit) begin
            trig      <= 1'b0;
            err       <= 1'b1;
            timed_out <= 1'b1;
            ph_cnt    <= '0;
            state     <= S_GAP;
          end else if ((state == S_TRIG) && (ph_cnt == TRIG_LAST)) begin
            trig  <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_GAP: begin
          if (abort) begin
            clr_mode  <= 1'b0;
            clr_2_one <= 1'b0;
            state     <= S_IDLE;
          end else if (gap_end) begin
            if (more_reps) begin
              trig   <= 1'b1;
              to_cnt <= '0;
              ph_cnt <= '0;
              state  <= S_TRIG;
            end else begin
              clr_mode  <= 1'b0;
              clr_2_one <= 1'b0;
              state     <= S_IDLE;
            end
          end else begin
            ph_cnt <= ph_cnt + 8'd1;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            clr_mode  <= 1'b0;
            clr_2_one <= 1'b0;
            state     <= S_IDLE;
          end else if (ph_cnt == CLR_LAST) begin
            clr_mode  <= 1'b0;
            clr_2_one <= 1'b0;
            ph_cnt    <= '0;
            state     <= S_GAP;
          end else begin
            ph_cnt <= ph_cnt + 8'd1;
          end
        end
        S_DRAIN: begin
          // Let the driver finish its in-flight sequence before going idle.
          to_cnt <= to_nxt;
          if (syn_rise) begin
            state <= S_IDLE;
          end else if (to_hit) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          trig      <= 1'b0;
          clr_mode  <= 1'b0;
          clr_2_one <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shr_seq_ctrl.sv
// Directed bench for shr_seq_ctrl: scoreboard queues of expected trig/clear/done events,
// a behavioural pattern-driver model answering trig with syn after a programmable delay.
module tb_shr_seq_ctrl;
  localparam int TRIG_W     = 2;
  localparam int GAP        = 8;
  localparam int CLR_CYCLES = 16;
  localparam int TO_MARGIN  = 64;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       abort  = 1'b0;
  logic       syn    = 1'b0;
  logic       trig;
  logic [9:0] seq_length;
  logic [1:0] bank_sel;
  logic       clr_mode;
  logic       clr_2_one;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] fifo_level;
`ifdef SHR_SEQ_CTRL_LOOP_EN
  logic       loop_en = 1'b0;
`endif

  shr_seq_ctrl_if cmd_if();

  shr_seq_ctrl #(
    .FIFO_DEPTH(4), .TRIG_W(TRIG_W), .GAP(GAP), .CLR_CYCLES(CLR_CYCLES), .TO_MARGIN(TO_MARGIN)
  ) dut (
    .clk_in(clk_in), .rst(rst), .cmd(cmd_if), .abort(abort), .syn(syn),
`ifdef SHR_SEQ_CTRL_LOOP_EN
    .loop_en(loop_en),
`endif
    .trig(trig), .seq_length(seq_length), .bank_sel(bank_sel), .clr_mode(clr_mode),
    .clr_2_one(clr_2_one), .busy(busy), .done(done), .err(err), .fifo_level(fifo_level)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int syn_dly = 12;
  bit syn_en = 1'b1;
  int done_cnt = 0;
  logic [11:0] trig_q [$];
  bit          clr_q  [$];
  int          done_q [$];
  int          rise_cyc [$];

  initial forever #5 clk_in = ~clk_in;
  initial forever begin @(posedge clk_in); cyc++; end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pattern-driver model: syn pulses one cycle, syn_dly cycles after trig rises.
  initial begin
    int scnt;
    bit tseen;
    scnt = 1000;
    tseen = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        scnt = 1000; tseen = 1'b0; syn = 1'b0;
      end else begin
        if (trig && !tseen) scnt = 0;
        else if (scnt < 1000) scnt++;
        tseen = trig;
        syn = syn_en && (scnt == syn_dly);
      end
    end
  end

  // Output monitor / scoreboard consumer.
  initial begin
    logic trig_d, clr_d, done_d;
    int tw, cw;
    logic [11:0] e;
    trig_d = 0; clr_d = 0; done_d = 0; tw = 0; cw = 0;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        trig_d = 0; clr_d = 0; done_d = 0;
      end else begin
        if (trig && !trig_d) begin
          rise_cyc.push_back(cyc);
          tw = 1;
          check("trig_expected", 32'(trig_q.size() != 0), 1);
          if (trig_q.size() != 0) begin
            e = trig_q.pop_front();
            check("bank_sel", 32'(bank_sel), 32'(e[11:10]));
            check("seq_length", 32'(seq_length), 32'(e[9:0]));
          end
          check("trig_clr_mode", 32'(clr_mode), 0);
        end else if (trig) tw++;
        else if (trig_d) check("trig_width", tw, TRIG_W);

        if (clr_mode && !clr_d) begin
          cw = 1;
          check("clr_expected", 32'(clr_q.size() != 0), 1);
          if (clr_q.size() != 0) check("clr_2_one", 32'(clr_2_one), 32'(clr_q.pop_front()));
        end else if (clr_mode) cw++;
        else if (clr_d) check("clr_hold", cw, CLR_CYCLES);
        check("clr_combo_legal", 32'({clr_mode, clr_2_one} != 2'b01), 1);

        if (done) begin
          done_cnt++;
          check("done_expected", 32'(done_q.size() != 0), 1);
          if (done_q.size() != 0) void'(done_q.pop_front());
          check("done_single", 32'(done_d), 0);
`ifdef SHR_SEQ_CTRL_LOOP_EN
          check("loop_level", 32'(fifo_level), loop_en ? 1 : 0);
`endif
        end
        trig_d = trig; clr_d = clr_mode; done_d = done;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    check("rst_trig", 32'(trig), 0);
    check("rst_seq_length", 32'(seq_length), 0);
    check("rst_bank_sel", 32'(bank_sel), 0);
    check("rst_clr", 32'({clr_mode, clr_2_one}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    check("rst_cmd_ready", 32'(cmd_if.cmd_ready), 1);
    trig_q.delete(); clr_q.delete(); done_q.delete(); rise_cyc.delete();
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] bank,
                      input logic [9:0] len, input logic [7:0] rep);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op = op; cmd_if.cmd_bank = bank; cmd_if.cmd_len = len; cmd_if.cmd_rep = rep;
    @(negedge clk_in);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk_in);
    while ((busy || fifo_level != 0) && n < budget) begin @(negedge clk_in); n++; end
    check(tag, 32'({busy, fifo_level}), 0);
  endtask

  task automatic wait_trig(input string tag, input int budget);
    int n;
    n = 0;
    while (trig !== 1'b1 && n < budget) begin @(negedge clk_in); n++; end
    check(tag, 32'(trig), 1);
  endtask

  task automatic queues_empty(input string tag);
    check({tag, "_trig_q"}, trig_q.size(), 0);
    check({tag, "_clr_q"},  clr_q.size(), 0);
    check({tag, "_done_q"}, done_q.size(), 0);
  endtask

  initial begin
    int n, err_cyc;
    cmd_if.cmd_valid = 0; cmd_if.cmd_op = 0; cmd_if.cmd_bank = 0;
    cmd_if.cmd_len = 0; cmd_if.cmd_rep = 0;
    do_reset();

    // Pattern, 3 repeats, syn 12 cycles after each trig
    syn_en = 1; syn_dly = 12;
    for (int i = 0; i < 3; i++) trig_q.push_back({2'd2, 10'd10});
    done_q.push_back(0);
    push(2'b00, 2'd2, 10'd10, 8'd3);
    wait_idle("A_idle", 2000);
    check("A_pulses", rise_cyc.size(), 3);
    if (rise_cyc.size() == 3) begin
      check("A_period1", rise_cyc[1] - rise_cyc[0], syn_dly + 1 + GAP);
      check("A_period2", rise_cyc[2] - rise_cyc[1], syn_dly + 1 + GAP);
    end
    check("A_err", 32'(err), 0);
    queues_empty("A");

    // Clear-to-ones then clear-to-zeros back-to-back
    rise_cyc.delete();
    clr_q.push_back(1'b1); clr_q.push_back(1'b0);
    done_q.push_back(1); done_q.push_back(2);
    push(2'b01, 2'd0, 10'd0, 8'd5);
    push(2'b10, 2'd0, 10'd0, 8'd0);
    wait_idle("B_idle", 2000);
    check("B_no_trig", rise_cyc.size(), 0);
    check("B_err", 32'(err), 0);
    queues_empty("B");

    // Missing syn -> timeout at len+TO_MARGIN, next entry still runs
    syn_en = 0; rise_cyc.delete();
    trig_q.push_back({2'd1, 10'd20});
    clr_q.push_back(1'b0); done_q.push_back(2);
    push(2'b00, 2'd1, 10'd20, 8'd1);
    push(2'b10, 2'd0, 10'd0, 8'd1);
    n = 0;
    while (err !== 1'b1 && n < 500) begin @(negedge clk_in); n++; end
    err_cyc = cyc;
    check("C_err_set", 32'(err), 1);
    check("C_one_trig", rise_cyc.size(), 1);
    if (rise_cyc.size() == 1) check("C_to_latency", err_cyc - rise_cyc[0], 20 + TO_MARGIN);
    wait_idle("C_idle", 2000);
    check("C_err_sticky", 32'(err), 1);
    queues_empty("C");
    syn_en = 1;

    // Asynchronous reset while trig is high
    trig_q.push_back({2'd3, 10'd30});
    push(2'b00, 2'd3, 10'd30, 8'd2);
    wait_trig("R_trig", 50);
    do_reset();

    // Fill FIFO, ignore push while full, abort during WAIT_SYN -> DRAIN
    syn_dly = 40;
    trig_q.push_back({2'd0, 10'd100});
    push(2'b00, 2'd0, 10'd100, 8'd1);
    wait_trig("D_trig", 50);
    for (int i = 0; i < 4; i++) push(2'b00, 2'd1, 10'd50, 8'd2);
    check("D_level_full", 32'(fifo_level), 4);
    check("D_ready_full", 32'(cmd_if.cmd_ready), 0);
    push(2'b01, 2'd0, 10'd0, 8'd1);
    check("D_push_ignored", 32'(fifo_level), 4);
    check("D_full_no_err", 32'(err), 0);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    check("D_flush", 32'(fifo_level), 0);
    check("D_busy_abort", 32'(busy), 1);
    check("D_trig_low", 32'(trig), 0);
    n = 0;
    do begin @(negedge clk_in); #1; n++; end while (!syn && n < 200);
    check("D_syn_seen", 32'(syn), 1);
    check("D_busy_drain", 32'(busy), 1);
    @(negedge clk_in);
    check("D_idle_after_syn", 32'(busy), 0);
    check("D_err", 32'(err), 0);
    queues_empty("D");

    // Abort concurrent with a push: the entry is discarded
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 2'b01; abort = 1'b1;
    @(negedge clk_in);
    cmd_if.cmd_valid = 1'b0; abort = 1'b0;
    check("D2_level", 32'(fifo_level), 0);
    @(negedge clk_in);
    check("D2_not_busy", 32'(busy), 0);

    // Rejected commands
    rise_cyc.delete();
    push(2'b11, 2'd0, 10'd5, 8'd1);
    push(2'b00, 2'd0, 10'd0, 8'd1);
    wait_idle("E_idle", 200);
    check("E_err", 32'(err), 1);
    check("E_no_trig", rise_cyc.size(), 0);
    queues_empty("E");
    do_reset();
    check("E_err_cleared", 32'(err), 0);

`ifdef SHR_SEQ_CTRL_LOOP_EN
    // Loop mode: re-push on completion until loop_en drops
    syn_dly = 12; loop_en = 1'b1; done_cnt = 0; rise_cyc.delete();
    for (int i = 0; i < 3; i++) begin trig_q.push_back({2'd3, 10'd8}); done_q.push_back(0); end
    push(2'b00, 2'd3, 10'd8, 8'd1);
    n = 0;
    while (done_cnt < 2 && n < 1000) begin @(negedge clk_in); #1; n++; end
    loop_en = 1'b0;
    wait_idle("L_idle", 1000);
    check("L_pulses", rise_cyc.size(), 3);
    queues_empty("L");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shr_seq_ctrl.md
Name: shr_seq_ctrl

Overview:
- Command-driven sequencer for the serial shift-register pattern driver (clk/dout/syn output stage).
- Host pushes commands into a 4-deep FIFO. Each command is one of: run pattern bank N for seq_length bits, R times; or a clear-to-ones / clear-to-zeros hold.
- Block drives trig, seq_length, bank select and the clr_mode/clr_2_one pair, waits for syn, inserts gaps, flags timeouts.
- Sits between the host/vJTAG register file and the pattern driver, in the clk_in domain.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2.
- TRIG_W, 2, trig pulse width in clk_in cycles; range 1..15.
- GAP, 8, idle clk_in cycles between repeats and between commands; 0 allowed.
- CLR_CYCLES, 16, cycles the clear level is held; range 1..255.
- TO_MARGIN, 64, extra cycles beyond seq_length before a missing syn is a timeout.

Ports:
- clk_in  in  1  sole clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command push request.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  2  00 pattern, 01 clear-to-ones, 10 clear-to-zeros, 11 reserved.
- cmd_bank  in  2  pattern bank index.
- cmd_len  in  10  sequence length in bits.
- cmd_rep  in  8  repeat count; 0 is treated as 1.
- abort  in  1  single-cycle abort request.
- syn  in  1  sync pulse from the pattern driver.
- trig  out  1  trigger to the pattern driver.
- seq_length  out  10  length to the pattern driver.
- bank_sel  out  2  selects the data_reg source.
- clr_mode  out  1  to the pattern driver.
- clr_2_one  out  1  to the pattern driver.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse on normal command completion.
- err  out  1  sticky; cleared only by rst.
- fifo_level  out  3  number of entries in the FIFO, 0..4.

Behaviour:
- Reset values: trig=0, seq_length=0, bank_sel=0, clr_mode=0, clr_2_one=0, busy=0, done=0, err=0, fifo_level=0, cmd_ready=1, FSM=IDLE, FIFO empty.
- Push: occurs when cmd_valid && cmd_ready. A push and a pop in the same cycle leave fifo_level unchanged. A push while full is ignored and does not set err.
- syn edge: syn is registered once; syn_rise = syn && !syn_q.
- IDLE: if the FIFO is non-empty, pop the head and go to LOAD (1 cycle). In LOAD, latch the outputs from the entry and set rep_cnt = max(cmd_rep,1).
- Validation in LOAD: op 11, or op 00 with len 0, sets err, drops the entry, goes to IDLE, and does not pulse done.
- Output mapping:
  - op 00: clr_mode=0, clr_2_one=0.
  - op 01: clr_mode=1, clr_2_one=1.
  - op 10: clr_mode=1, clr_2_one=0.
  - The combination clr_mode=0 with clr_2_one=1 is never driven.
- Pattern path:
  - LOAD -> TRIG: trig=1 for exactly TRIG_W cycles; the timeout counter starts at 0 on TRIG entry.
  - -> WAIT_SYN: trig=0, counter increments each cycle.
  - syn_rise during TRIG or WAIT_SYN -> GAP; decrement rep_cnt.
  - Counter reaching cmd_len+TO_MARGIN (12-bit compare) before syn_rise: set err, pop no further repeats, go to GAP.
- GAP: hold for GAP cycles; GAP=0 means pass through in 1 cycle.
- After GAP:
  - rep_cnt>0 and no timeout: go to TRIG.
  - Otherwise: pulse done (only if no timeout occurred on this command), clear clr_mode/clr_2_one, go to IDLE.
- Clear path: LOAD -> CLEAR. Hold clr_mode/clr_2_one for CLR_CYCLES, never assert trig, ignore cmd_rep, then GAP -> IDLE with done.
- Abort:
  - Flushes the FIFO in the same cycle.
  - From TRIG or WAIT_SYN: trig drops next cycle, go to DRAIN. DRAIN waits for syn_rise or timeout, so the driver finishes its in-flight sequence, then goes to IDLE. No done; err is set only if the timeout fires.
  - From LOAD, GAP or CLEAR: go to IDLE next cycle with clear outputs deasserted.
- Abort concurrent with a push: the flush wins and the pushed entry is discarded.
- busy=1 in every state except IDLE, including DRAIN.
- rst mid-operation: all outputs return to their reset values immediately and asynchronously. The pattern driver may still complete its current sequence.

Optional Feature:
- SHR_SEQ_CTRL_LOOP_EN.
- Defined: adds input port loop_en (1 bit). On normal completion of a command while loop_en=1, the entry is re-pushed at the FIFO tail, with priority over a host push in the same cycle (host push then waits since cmd_ready=0). Gives continuous pattern cycling until abort or loop_en=0. Timed-out or rejected entries are never re-pushed.
- Undefined: no loop_en port; entries are consumed once.

Test Plan:
- Push {op00,bank2,len10,rep3}; model the driver asserting syn 12 cycles after trig → 3 trig pulses each TRIG_W=2 wide, gaps of 8 cycles, bank_sel=2, seq_length=10, one done pulse, err=0.
- Push op01 then op10 back-to-back → clr_mode=1/clr_2_one=1 for 16 cycles, gap, then clr_mode=1/clr_2_one=0 for 16 cycles; trig stays 0; two done pulses.
- Push {op00,len20,rep1} with syn never asserted → err=1 exactly 84 cycles after TRIG entry, no done, FSM returns to IDLE, next FIFO entry proceeds.
- Fill FIFO with 4 entries (cmd_ready=0, fifo_level=4), then abort during WAIT_SYN → fifo_level=0 next cycle, busy held until syn, no done, err=0.
- Push {op11} and {op00,len0} → err=1, both dropped, no trig, no done; rst then clears err to 0.
- With SHR_SEQ_CTRL_LOOP_EN and loop_en=1, single entry rep1 → trig repeats indefinitely and fifo_level returns to 1 after each completion; deassert loop_en → stops after the current command.
